// File: rtl/kgp_risc_pkg.sv
// Shared types and constants for the sequencing/branch path.
// FSM state encoding and branch-condition codes.
package kgp_risc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] UC_NEVER  = 2'b00;
  localparam logic [1:0] UC_ALWAYS = 2'b01;
  localparam logic [1:0] UC_CARRY  = 2'b11;
  localparam logic [1:0] UC_NCARRY = 2'b10;

  localparam logic [1:0] CC_NEVER = 2'b00;
  localparam logic [1:0] CC_LTZ   = 2'b10;
  localparam logic [1:0] CC_ZERO  = 2'b11;
  localparam logic [1:0] CC_NZ    = 2'b01;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution: taken flag and next PC.
// Priority RegBr > UncondBr > CondBr; targets wrap mod 2^32.
module branch_resolve
  import kgp_risc_pkg::*;
#(
  parameter int OFF_W = 26
) (
  input  logic [31:0]      pc,
  input  logic             condBr,
  input  logic             regBr,
  input  logic             uncondBr,
  input  logic [1:0]       uncondControl,
  input  logic [1:0]       condControl,
  input  logic [OFF_W-1:0] branchOffset,
  input  logic [31:0]      rsValue,
  input  logic             carry,
  output logic             taken,
  output logic [31:0]      nextPc
);

  logic [31:0] pcPlus4;
  logic [31:0] offWord;
  logic [31:0] relTarget;
  logic        ucTake;
  logic        ccTake;

  assign pcPlus4   = pc + 32'd4;
  assign offWord   = {{(32-OFF_W){branchOffset[OFF_W-1]}},
                      branchOffset};
  assign relTarget = pcPlus4 + {offWord[29:0], 2'b00};

  // evaluate unconditional-class and conditional-class tests
  always_comb begin
    ucTake = 1'b0;
    ccTake = 1'b0;
    unique case (uncondControl)
      UC_NEVER:  ucTake = 1'b0;
      UC_ALWAYS: ucTake = 1'b1;
      UC_CARRY:  ucTake = carry;
      UC_NCARRY: ucTake = ~carry;
      default:   ucTake = 1'b0;
    endcase
    unique case (condControl)
      CC_NEVER: ccTake = 1'b0;
      CC_LTZ:   ccTake = rsValue[31];
      CC_ZERO:  ccTake = (rsValue == 32'd0);
      CC_NZ:    ccTake = (rsValue != 32'd0);
      default:  ccTake = 1'b0;
    endcase
  end

  // pick branch class by priority and form the next PC
  always_comb begin
    taken  = 1'b0;
    nextPc = pcPlus4;
    priority case (1'b1)
      regBr: begin
        taken  = 1'b1;
        nextPc = {rsValue[31:2], 2'b00};
      end
      uncondBr: begin
        taken  = ucTake;
        nextPc = ucTake ? relTarget : pcPlus4;
      end
      condBr: begin
        taken  = ccTake;
        nextPc = ccTake ? relTarget : pcPlus4;
      end
      default: begin
        taken  = 1'b0;
        nextPc = pcPlus4;
      end
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register, fetch handshake and branch commit sequencer.
// Optional counters: define BRANCH_PC_STATS_EN.
module branch_pc_unit
  import kgp_risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          OFF_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             instrReq,
  output logic [31:0]      fetchAddr,
  input  logic [31:0]      instrIn,
  input  logic             instrValid,
  output logic [31:0]      instrReg,
  input  logic             CondBr,
  input  logic             RegBr,
  input  logic             UncondBr,
  input  logic [1:0]       UncondControl,
  input  logic [1:0]       CondControl,
  input  logic [OFF_W-1:0] branchOffset,
  input  logic [31:0]      rsValue,
  input  logic             carryIn,
  input  logic             carryWe,
  input  logic             exStall,
  input  logic             haltReq,
  output logic [31:0]      pc,
  output logic [31:0]      linkAddr,
  output logic             instrDone,
  output logic             branchTaken,
`ifdef BRANCH_PC_STATS_EN
  output logic [31:0]      instrCount,
  output logic [31:0]      takenCount,
`endif
  output logic             halted
);

  state_t      state;
  state_t      stateNext;
  logic        carry;
  logic        taken;
  logic [31:0] nextPc;
  logic        commit;

  assign commit    = (state == S_EXEC) && !exStall;
  assign fetchAddr = pc;
  assign linkAddr  = pc + 32'd4;
  assign halted    = (state == S_HALT);

  branch_resolve #(
    .OFF_W(OFF_W)
  ) uResolve (
    .pc           (pc),
    .condBr       (CondBr),
    .regBr        (RegBr),
    .uncondBr     (UncondBr),
    .uncondControl(UncondControl),
    .condControl  (CondControl),
    .branchOffset (branchOffset),
    .rsValue      (rsValue),
    .carry        (carry),
    .taken        (taken),
    .nextPc       (nextPc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  // next state and fetch request
  always_comb begin
    stateNext = state;
    instrReq  = 1'b0;
    unique case (state)
      S_IDLE:  stateNext = S_FETCH;
      S_FETCH: begin
        instrReq  = 1'b1;
        stateNext = S_WAIT;
      end
      S_WAIT: begin
        instrReq = 1'b1;
        if (instrValid) stateNext = S_EXEC;
      end
      S_EXEC: begin
        if (!exStall)
          stateNext = haltReq ? S_HALT : S_FETCH;
      end
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_IDLE;
    endcase
  end

  // PC, held instruction and commit pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instrReg    <= 32'd0;
      instrDone   <= 1'b0;
      branchTaken <= 1'b0;
    end else begin
      instrDone   <= commit;
      branchTaken <= commit && taken;
      if (state == S_WAIT && instrValid)
        instrReg <= instrIn;
      if (commit)
        pc <= nextPc;
    end
  end

  // carry flag, writable in any state
  always_ff @(posedge clk) begin
    if (!rst_n)       carry <= 1'b0;
    else if (carryWe) carry <= carryIn;
  end

`ifdef BRANCH_PC_STATS_EN
  // commit and taken-branch counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instrCount <= 32'd0;
      takenCount <= 32'd0;
    end else if (commit) begin
      instrCount <= instrCount + 32'd1;
      if (taken) takenCount <= takenCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit.
// Directed instruction stream against a cycle-scheduled model.
module tb_branch_pc_unit;

  localparam int OFF_W = 26;

  typedef struct packed {
    logic             cb;
    logic             rb;
    logic             ub;
    logic [1:0]       uc;
    logic [1:0]       cc;
    logic [OFF_W-1:0] off;
    logic [31:0]      rs;
  } dec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instrReq;
  logic [31:0]      fetchAddr;
  logic [31:0]      instrIn = '0;
  logic             instrValid = 1'b0;
  logic [31:0]      instrReg;
  logic             CondBr = 1'b0;
  logic             RegBr = 1'b0;
  logic             UncondBr = 1'b0;
  logic [1:0]       UncondControl = '0;
  logic [1:0]       CondControl = '0;
  logic [OFF_W-1:0] branchOffset = '0;
  logic [31:0]      rsValue = '0;
  logic             carryIn = 1'b0;
  logic             carryWe = 1'b0;
  logic             exStall = 1'b0;
  logic             haltReq = 1'b0;
  logic [31:0]      pc;
  logic [31:0]      linkAddr;
  logic             instrDone;
  logic             branchTaken;
  logic             halted;
`ifdef BRANCH_PC_STATS_EN
  logic [31:0]      instrCount;
  logic [31:0]      takenCount;
`endif

  branch_pc_unit #(
    .RESET_PC(32'h0),
    .OFF_W   (OFF_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instrReq     (instrReq),
    .fetchAddr    (fetchAddr),
    .instrIn      (instrIn),
    .instrValid   (instrValid),
    .instrReg     (instrReg),
    .CondBr       (CondBr),
    .RegBr        (RegBr),
    .UncondBr     (UncondBr),
    .UncondControl(UncondControl),
    .CondControl  (CondControl),
    .branchOffset (branchOffset),
    .rsValue      (rsValue),
    .carryIn      (carryIn),
    .carryWe      (carryWe),
    .exStall      (exStall),
    .haltReq      (haltReq),
    .pc           (pc),
    .linkAddr     (linkAddr),
    .instrDone    (instrDone),
    .branchTaken  (branchTaken),
`ifdef BRANCH_PC_STATS_EN
    .instrCount   (instrCount),
    .takenCount   (takenCount),
`endif
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic        chkOn = 1'b0;
  logic [31:0] expPc = '0;
  logic        expReq = 1'b0;
  logic        expDone = 1'b0;
  logic        expTaken = 1'b0;
  logic        expHalted = 1'b0;
  logic        mCarry = 1'b0;
  logic [31:0] mInstr = '0;
  logic [31:0] mTakenCnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chkOn) begin
      check("pc", pc, expPc);
      check("fetchAddr", fetchAddr, expPc);
      check("linkAddr", linkAddr, expPc + 32'd4);
      check("instrReq", {31'd0, instrReq}, {31'd0, expReq});
      check("instrDone", {31'd0, instrDone}, {31'd0, expDone});
      check("branchTaken", {31'd0, branchTaken},
            {31'd0, expTaken});
      check("halted", {31'd0, halted}, {31'd0, expHalted});
`ifdef BRANCH_PC_STATS_EN
      check("instrCount", instrCount, mInstr);
      check("takenCount", takenCount, mTakenCnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    expDone  = 1'b0;
    expTaken = 1'b0;
  endtask

  function automatic void modelNext(input logic [31:0] p,
                                    input dec_t d,
                                    input logic c,
                                    output logic [31:0] np,
                                    output logic tk);
    logic [31:0] seq;
    logic [31:0] tgt;
    int          offw;
    seq  = p + 32'd4;
    offw = int'($signed(d.off));
    tgt  = seq + 32'(offw * 4);
    tk   = 1'b0;
    np   = seq;
    if (d.rb) begin
      tk = 1'b1;
      np = d.rs & 32'hFFFF_FFFC;
    end else if (d.ub) begin
      if (d.uc == 2'b01) tk = 1'b1;
      if (d.uc == 2'b11 && c) tk = 1'b1;
      if (d.uc == 2'b10 && !c) tk = 1'b1;
      if (tk) np = tgt;
    end else if (d.cb) begin
      if (d.cc == 2'b10 && d.rs[31]) tk = 1'b1;
      if (d.cc == 2'b11 && d.rs == 0) tk = 1'b1;
      if (d.cc == 2'b01 && d.rs != 0) tk = 1'b1;
      if (tk) np = tgt;
    end
  endfunction

  function automatic dec_t mk(input logic cb, input logic rb,
                              input logic ub,
                              input logic [1:0] uc,
                              input logic [1:0] cc,
                              input int off,
                              input logic [31:0] rs);
    dec_t d;
    d.cb  = cb;
    d.rb  = rb;
    d.ub  = ub;
    d.uc  = uc;
    d.cc  = cc;
    d.off = OFF_W'(off);
    d.rs  = rs;
    return d;
  endfunction

  task automatic resetModel();
    expPc     = 32'h0;
    expReq    = 1'b0;
    expHalted = 1'b0;
    mCarry    = 1'b0;
    mInstr    = '0;
    mTakenCnt = '0;
  endtask

  // cwPhase: 0 none, 1 carry write in WAIT, 2 in committing EXEC
  task automatic execInstr(input logic [31:0] word,
                           input dec_t d,
                           input int waitLat,
                           input int stalls,
                           input logic halt,
                           input int cwPhase,
                           input logic cwVal);
    logic [31:0] np;
    logic        tk;
    tick();
    repeat (waitLat) tick();
    instrValid = 1'b1;
    instrIn    = word;
    if (cwPhase == 1) begin
      carryWe = 1'b1;
      carryIn = cwVal;
    end
    tick();
    instrValid = 1'b0;
    instrIn    = 32'h0;
    carryWe    = 1'b0;
    if (cwPhase == 1) mCarry = cwVal;
    expReq = 1'b0;
    check("instrReg", instrReg, word);
    CondBr        = d.cb;
    RegBr         = d.rb;
    UncondBr      = d.ub;
    UncondControl = d.uc;
    CondControl   = d.cc;
    branchOffset  = d.off;
    rsValue       = d.rs;
    haltReq       = halt;
    exStall       = 1'b1;
    repeat (stalls) tick();
    exStall = 1'b0;
    modelNext(expPc, d, mCarry, np, tk);
    if (cwPhase == 2) begin
      carryWe = 1'b1;
      carryIn = cwVal;
    end
    tick();
    carryWe = 1'b0;
    if (cwPhase == 2) mCarry = cwVal;
    CondBr   = 1'b0;
    RegBr    = 1'b0;
    UncondBr = 1'b0;
    haltReq  = 1'b0;
    rsValue  = '0;
    expPc     = np;
    expDone   = 1'b1;
    expTaken  = tk;
    expReq    = !halt;
    expHalted = halt;
    mInstr    = mInstr + 1;
    if (tk) mTakenCnt = mTakenCnt + 1;
  endtask

  dec_t nob;
  int   c0;
  int   c1;

  initial begin
    nob = mk(0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
    // reset state
    rst_n = 1'b0;
    tick();
    resetModel();
    chkOn = 1'b1;
    tick();
    check("rst_instrReg", instrReg, 32'h0);
    rst_n = 1'b1;
    tick();
    expReq = 1'b1;

    // sequential fetch, 3 cycles per instruction
    c0 = cyc;
    execInstr(32'h1111_0001, nob, 0, 0, 0, 0, 0);
    check("lit_pc_4", pc, 32'h4);
    c1 = cyc;
    execInstr(32'h1111_0002, nob, 0, 0, 0, 0, 0);
    check("lit_pc_8", pc, 32'h8);
    check("lit_cpi", 32'(c1 - c0), 32'd3);
    execInstr(32'h1111_0003, nob, 0, 0, 0, 0, 0);
    execInstr(32'h1111_0004, nob, 3, 0, 0, 0, 0);
    check("lit_pc_16", pc, 32'h10);

    // register branch then relative uncond with negative offset
    execInstr(32'h2000_0001, mk(0, 1, 0, 0, 0, 0, 32'h100),
              0, 0, 0, 0, 0);
    check("lit_pc_100", pc, 32'h100);
    execInstr(32'h2000_0002,
              mk(0, 0, 1, 2'b01, 0, -2, 0), 0, 0, 0, 0, 0);
    check("lit_pc_fc", pc, 32'hFC);

    // carry written before EXEC is seen; in EXEC it is not
    execInstr(32'h3000_0001,
              mk(0, 0, 1, 2'b11, 0, 1, 0), 0, 0, 0, 1, 1'b1);
    check("lit_bcy_taken", pc, 32'h104);
    execInstr(32'h3000_0002, nob, 0, 0, 0, 1, 1'b0);
    execInstr(32'h3000_0003,
              mk(0, 0, 1, 2'b11, 0, 1, 0), 0, 0, 0, 2, 1'b1);
    check("lit_bcy_nt", pc, 32'h10C);
    execInstr(32'h3000_0004,
              mk(0, 0, 1, 2'b10, 0, 5, 0), 0, 0, 0, 0, 0);
    execInstr(32'h3000_0005,
              mk(0, 0, 1, 2'b00, 0, 5, 0), 0, 0, 0, 0, 0);

    // conditional branches on rs
    execInstr(32'h4000_0001,
              mk(1, 0, 0, 0, 2'b10, 3, 32'h8000_0000),
              0, 0, 0, 0, 0);
    check("lit_ltz", pc, 32'h124);
    execInstr(32'h4000_0002,
              mk(1, 0, 0, 0, 2'b11, 3, 32'h1), 0, 0, 0, 0, 0);
    check("lit_zero_nt", pc, 32'h128);
    execInstr(32'h4000_0003,
              mk(1, 0, 0, 0, 2'b01, -1, 32'h1), 0, 0, 0, 0, 0);
    check("lit_nz", pc, 32'h128);
    execInstr(32'h4000_0004,
              mk(1, 0, 0, 0, 2'b11, 0, 32'h0), 0, 1, 0, 0, 0);
    execInstr(32'h4000_0005,
              mk(1, 0, 0, 0, 2'b00, 7, 32'h5), 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space
    execInstr(32'h5000_0001,
              mk(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 0, 0, 0, 0, 0);
    check("lit_pc_top", pc, 32'hFFFF_FFFC);
    execInstr(32'h5000_0002, nob, 0, 0, 0, 0, 0);
    check("lit_pc_wrap", pc, 32'h0);

    // priority, misaligned rs, then stalled halt
    execInstr(32'h6000_0001,
              mk(1, 1, 1, 2'b01, 2'b01, 5, 32'h203),
              0, 0, 0, 0, 0);
    check("lit_prio", pc, 32'h200);
    execInstr(32'h6000_0002, nob, 0, 2, 1'b1, 0, 0);
    check("lit_halt_pc", pc, 32'h204);
    repeat (3) tick();
    check("lit_halted", {31'd0, halted}, 32'd1);

    // reset while waiting; stale valid afterwards ignored
    rst_n = 1'b0;
    tick();
    resetModel();
    rst_n = 1'b1;
    tick();
    expReq = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    resetModel();
    rst_n      = 1'b1;
    instrValid = 1'b1;
    instrIn    = 32'hDEAD_BEEF;
    tick();
    instrValid = 1'b0;
    instrIn    = 32'h0;
    expReq     = 1'b1;
    check("lit_rst_instrReg", instrReg, 32'h0);
    check("lit_rst_pc", pc, 32'h0);
    execInstr(32'h7000_0001, nob, 1, 0, 0, 0, 0);
    check("lit_after_rst", pc, 32'h4);
    tick();

    chkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
